// File: rtl/rsa_host_ctrl_pkg.sv
// Shared definitions for the RSA host controller: FSM encoding, operand register selects, frame sizes.
package rsa_host_ctrl_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned ADDR_W        = 5;
  localparam int unsigned SEL_W         = 2;
  localparam int unsigned CNT_W         = 7;
  localparam int unsigned OPERAND_BYTES = 32;
  localparam int unsigned FRAME_BYTES   = 96;

  localparam logic [SEL_W-1:0] REG_M = 2'b01;
  localparam logic [SEL_W-1:0] REG_E = 2'b10;
  localparam logic [SEL_W-1:0] REG_N = 2'b11;

  typedef enum logic [2:0] {
    LOAD     = 3'd0,
    START    = 3'd1,
    WAIT     = 3'd2,
    READ_REQ = 3'd3,
    READ_CAP = 3'd4,
    OUT      = 3'd5,
    RELEASE  = 3'd6
  } state_e;

  // Operand register for a frame byte position: M, then E, then N (equals 1 + cnt[6:5]).
  function automatic logic [SEL_W-1:0] load_sel(input logic [CNT_W-1:0] cnt);
    case (cnt[6:5])
      2'd0:    load_sel = REG_M;
      2'd1:    load_sel = REG_E;
      default: load_sel = REG_N;
    endcase
  endfunction

endpackage

// File: rtl/rsa_host_ctrl.sv
// Byte-stream front end for an RSA core: loads M/E/N, starts the core, streams the result out MSB first.
module rsa_host_ctrl
  import rsa_host_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              rsa_we,
  output logic              rsa_oe,
  output logic              rsa_start,
  output logic [SEL_W-1:0]  rsa_reg_sel,
  output logic [ADDR_W-1:0] rsa_addr,
  output logic [DATA_W-1:0] rsa_data_i,
  input  logic [DATA_W-1:0] rsa_data_o,
  input  logic              rsa_ready
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;

  assign out_data = out_data_q;

  // State, byte counter, read index and captured result byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOAD;
      cnt_q      <= '0;
      idx_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
    end
  end

  // Next-state and core/handshake strobes; all strobes forced low while reset is held.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    rsa_we      = 1'b0;
    rsa_oe      = 1'b0;
    rsa_start   = 1'b0;
    rsa_reg_sel = '0;
    rsa_addr    = '0;
    rsa_data_i  = '0;

    case (state_q)
      LOAD: begin
        busy     = 1'b0;
        in_ready = rsa_ready;
        if (in_valid && rsa_ready) begin
          rsa_we      = 1'b1;
          rsa_reg_sel = load_sel(cnt_q);
          rsa_addr    = ADDR_W'(5'd31 - cnt_q[4:0]);
          rsa_data_i  = in_data;
          if (cnt_q == CNT_W'(FRAME_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = START;
          end else begin
            cnt_d = CNT_W'(cnt_q + 7'd1);
          end
        end
      end
      START: begin
        rsa_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (rsa_ready) begin
          idx_d   = ADDR_W'(OPERAND_BYTES - 1);
          state_d = READ_REQ;
        end
      end
      READ_REQ: begin
        rsa_oe   = 1'b1;
        rsa_addr = idx_q;
        state_d  = READ_CAP;
      end
      READ_CAP: begin
        rsa_oe     = 1'b1;
        rsa_addr   = idx_q;
        out_data_d = rsa_data_o;
        state_d    = OUT;
      end
      OUT: begin
        rsa_oe    = 1'b1;
        rsa_addr  = idx_q;
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx_q == '0) begin
            state_d = RELEASE;
          end else begin
            idx_d   = ADDR_W'(idx_q - 5'd1);
            state_d = READ_REQ;
          end
        end
      end
      RELEASE: begin
        cnt_d   = '0;
        state_d = LOAD;
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    if (reset) begin
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      rsa_we      = 1'b0;
      rsa_oe      = 1'b0;
      rsa_start   = 1'b0;
      rsa_reg_sel = '0;
      rsa_addr    = '0;
      rsa_data_i  = '0;
    end
  end

endmodule

// File: tb/tb_rsa_host_ctrl.sv
// Self-checking bench for rsa_host_ctrl with a behavioural RSA core and a frame-level reference model.
module tb_rsa_host_ctrl;
  import rsa_host_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       rsa_we, rsa_oe, rsa_start;
  logic [1:0] rsa_reg_sel;
  logic [4:0] rsa_addr;
  logic [7:0] rsa_data_i;
  logic [7:0] rsa_data_o;
  logic       rsa_ready;

  always #5 clk = ~clk;

  rsa_host_ctrl dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy),
    .rsa_we(rsa_we), .rsa_oe(rsa_oe), .rsa_start(rsa_start),
    .rsa_reg_sel(rsa_reg_sel), .rsa_addr(rsa_addr),
    .rsa_data_i(rsa_data_i), .rsa_data_o(rsa_data_o), .rsa_ready(rsa_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Square-and-multiply modular exponentiation on 256-bit operands.
  function automatic logic [255:0] modexp(input logic [255:0] b, input logic [255:0] e,
                                          input logic [255:0] n);
    logic [511:0] r, x, nn;
    nn = {256'd0, n};
    r  = 512'd1;
    x  = {256'd0, b} % nn;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = (r * x) % nn;
      x = (x * x) % nn;
    end
    return r[255:0];
  endfunction

  // Frame operands and the byte stream that carries them
  logic [255:0] op_m = 256'd2;
  logic [255:0] op_e = 256'd3;
  logic [255:0] op_n = 256'd11;
  logic [255:0] exp_res;
  logic [7:0]   frame [96];

  // Behavioural RSA core: byte-addressed operand registers, fixed compute delay, registered readout.
  logic [255:0] core_op [4];
  logic [255:0] core_res;
  int           core_cnt;
  always @(posedge clk) begin
    if (reset) begin
      rsa_ready  <= 1'b1;
      rsa_data_o <= 8'h00;
      core_cnt   <= 0;
      core_res   <= '0;
      for (int i = 0; i < 4; i++) core_op[i] <= '0;
    end else begin
      if (rsa_we) core_op[rsa_reg_sel][rsa_addr*8 +: 8] <= rsa_data_i;
      if (rsa_start) begin
        core_res  <= modexp(core_op[1], core_op[2], core_op[3]);
        rsa_ready <= 1'b0;
        core_cnt  <= 20;
      end else if (core_cnt > 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) rsa_ready <= 1'b1;
      end
      if (rsa_oe) rsa_data_o <= core_res[rsa_addr*8 +: 8];
    end
  end

  // Reference model state (frame-level view of the controller)
  logic rst_at_edge = 1'b0;
  always @(posedge clk) rst_at_edge <= reset;

  bit       in_load   = 1'b1;
  bit       start_exp = 1'b0;
  bit       rel_exp   = 1'b0;
  bit       rel_next  = 1'b0;
  bit       reading   = 1'b0;
  bit       hold_prev = 1'b0;
  logic [7:0] hold_data;
  int       acc = 0;
  int       we_cnt = 0;
  int       outs = 0;
  int       outs_total = 0;
  int       frames_done = 0;

  // Cycle-by-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    logic       hs;
    logic [1:0] e_sel;
    logic [4:0] e_addr;
    bit         start_nx;
    if (rst_at_edge) begin
      in_load = 1'b1; start_exp = 1'b0; rel_exp = 1'b0; rel_next = 1'b0;
      reading = 1'b0; hold_prev = 1'b0; acc = 0; we_cnt = 0; outs = 0;
    end
    if (reset) begin
      if (rst_at_edge)
        chk("reset_outputs",
            64'({in_ready, out_valid, busy, rsa_we, rsa_oe, rsa_start,
                 rsa_reg_sel, rsa_addr, rsa_data_i, out_data}), 64'd0);
    end else begin
      hs = in_valid && in_ready;
      start_nx = 1'b0;
      chk("in_ready", 64'(in_ready), in_load ? 64'(rsa_ready) : 64'd0);
      chk("busy", 64'(busy), 64'(!in_load));
      chk("rsa_start", 64'(rsa_start), 64'(start_exp));
      chk("rsa_we", 64'(rsa_we), 64'(hs));
      if (rsa_we) we_cnt++;
      if (in_load || start_exp || rel_exp) begin
        chk("oe_idle", 64'(rsa_oe), 64'd0);
        chk("out_valid_idle", 64'(out_valid), 64'd0);
      end
      if (hold_prev) chk("out_hold", 64'({out_valid, out_data}), 64'({1'b1, hold_data}));
      if (out_valid) reading = 1'b1;
      if (reading && !rel_exp) chk("oe_continuous", 64'(rsa_oe), 64'd1);

      if (in_load && hs) begin
        e_sel  = (acc < 32) ? REG_M : (acc < 64) ? REG_E : REG_N;
        e_addr = 5'(31 - (acc % 32));
        chk("write", 64'({rsa_reg_sel, rsa_addr, rsa_data_i}), 64'({e_sel, e_addr, frame[acc]}));
        if (acc == 0)  chk("map_byte0",  64'({rsa_reg_sel, rsa_addr}), 64'({2'b01, 5'd31}));
        if (acc == 32) chk("map_byte32", 64'({rsa_reg_sel, rsa_addr}), 64'({2'b10, 5'd31}));
        if (acc == 95) chk("map_byte95", 64'({rsa_reg_sel, rsa_addr}), 64'({2'b11, 5'd0}));
        acc++;
        if (acc == 96) begin
          in_load  = 1'b0;
          start_nx = 1'b1;
        end
      end

      if (start_exp) begin
        chk("write_count", 64'(we_cnt), 64'd96);
        we_cnt = 0;
      end

      if (out_valid) begin
        if (outs >= 32) begin
          chk("extra_out", 64'(outs), 64'd31);
        end else begin
          chk("out_data", 64'(out_data), 64'(exp_res[(31 - outs)*8 +: 8]));
          if (out_ready) begin
            outs++;
            outs_total++;
            if (outs == 32) rel_next = 1'b1;
          end
        end
      end
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;

      if (rel_exp) begin
        in_load = 1'b1;
        acc = 0;
        outs = 0;
        reading = 1'b0;
        frames_done++;
      end
      rel_exp   = rel_next;
      rel_next  = 1'b0;
      start_exp = start_nx;
    end
  end

  // Downstream: accept every byte, except hold off for 10 valid cycles on byte 5 when stalling.
  bit stall_en = 1'b0;
  int stall_cnt = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_en && outs == 5 && out_valid && stall_cnt < 10) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Push the first nbytes of the frame; gap inserts one idle cycle after each byte.
  task automatic send_frame(input int nbytes, input bit gap);
    for (int k = 0; k < nbytes; k++) begin
      int n;
      in_valid = 1'b1;
      in_data  = frame[k];
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) begin
        errors++;
        $display("FAIL in_ready_timeout: got 0 expected 1 at byte %0d", k);
      end
      @(posedge clk);
      #1;
      if (gap) begin
        in_valid = 1'b0;
        in_data  = 8'hA5;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (frames_done < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (frames_done < target) begin
      errors++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", frames_done, target);
    end
  endtask

  initial begin
    for (int op = 0; op < 3; op++)
      for (int j = 0; j < 32; j++)
        frame[op*32 + j] = (op == 0) ? op_m[(31-j)*8 +: 8] :
                           (op == 1) ? op_e[(31-j)*8 +: 8] : op_n[(31-j)*8 +: 8];
    exp_res = modexp(op_m, op_e, op_n);

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Hand-computed anchors for the model: 2^3 mod 11 = 8, frame layout
    chk("model_result", 64'(exp_res), 64'd8);
    chk("frame_m_last", 64'(frame[31]), 64'h02);
    chk("frame_e_last", 64'(frame[63]), 64'h03);
    chk("frame_n_last", 64'(frame[95]), 64'h0B);
    chk("frame_first", 64'(frame[0]), 64'h00);

    // Contiguous frame; junk on in_valid during readout must be ignored
    send_frame(96, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    while (outs < 31 && frames_done < 1) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    wait_done(1);

    // Gapped input and a 10-cycle downstream stall on result byte 5
    stall_cnt = 0;
    stall_en  = 1'b1;
    send_frame(96, 1'b1);
    wait_done(2);
    stall_en = 1'b0;
    chk("stall_cycles", 64'(stall_cnt), 64'd10);

    // Reset after 40 bytes, then a fresh full frame
    send_frame(40, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    send_frame(96, 1'b0);
    wait_done(3);
    chk("result_bytes_total", 64'(outs_total), 64'd96);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_host_ctrl.md
RSA_HOST_CTRL -- requirements
Module: rsa_host_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port in_valid, input, 1 bit: upstream byte valid.
REQ-004 The block SHALL have port in_data, input, 8 bits: upstream byte.
REQ-005 The block SHALL have port in_ready, output, 1 bit: byte accepted when in_valid && in_ready at a clock edge.
REQ-006 The block SHALL have port out_valid, output, 1 bit: result byte valid.
REQ-007 The block SHALL have port out_data, output, 8 bits: result byte.
REQ-008 The block SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except LOAD.
REQ-010 The block SHALL have RSA-core ports rsa_we (out, 1), rsa_oe (out, 1), rsa_start (out, 1), rsa_reg_sel (out, 2), rsa_addr (out, 5), rsa_data_i (out, 8), rsa_data_o (in, 8) and rsa_ready (in, 1).

Function
REQ-011 Input frame SHALL be 96 bytes: M (reg_sel 01), then exponent E (reg_sel 10), then modulus N (reg_sel 11); each operand is sent MSB byte first, written to rsa_addr 31 down to 0.
REQ-012 In LOAD, in_ready SHALL equal rsa_ready. On each accepted byte the block SHALL drive rsa_we=1, rsa_reg_sel, rsa_addr and rsa_data_i=in_data in the same cycle.
REQ-013 In LOAD, the byte counter SHALL be 7 bits (0..95): reg_sel = 1 + count[6:5] and addr = 31 - count[4:0].
REQ-014 After byte 95 is accepted, the FSM SHALL enter START.
REQ-015 START SHALL last one cycle with rsa_start=1, rsa_we=0 and in_ready=0, then enter WAIT.
REQ-016 WAIT SHALL hold all rsa_* strobes at 0 and SHALL enter READ_REQ with the read index at 31 on the first cycle rsa_ready=1.
REQ-017 READ_REQ SHALL drive rsa_oe=1 and rsa_addr=index, then enter READ_CAP.
REQ-018 READ_CAP SHALL keep rsa_oe=1, load out_data from rsa_data_o (one-cycle registered core latency), then enter OUT.
REQ-019 OUT SHALL keep rsa_oe=1 and hold out_valid=1 with out_data stable until out_ready=1.
REQ-020 In OUT, on out_ready=1: if index=0 the FSM SHALL enter RELEASE; otherwise it SHALL decrement the index and enter READ_REQ.
REQ-021 RELEASE SHALL drive rsa_oe=0 for one cycle, returning the core to write state, then enter LOAD with the byte counter at 0.
REQ-022 rsa_oe SHALL be continuously 1 from READ_REQ of byte 31 through the OUT of byte 0.
REQ-023 Result bytes SHALL be emitted MSB first (addr 31..0); 32 bytes per frame.
REQ-024 in_valid SHALL be ignored in all states except LOAD; gaps in in_valid SHALL stall the counter with no write strobe.
REQ-025 out_valid SHALL be 0 in all states except OUT.
REQ-026 Throughput: LOAD 1 byte/cycle at best; readout 3 cycles/byte minimum.

Reset
REQ-027 On reset the FSM SHALL go to LOAD with the byte counter and read index at 0.
REQ-028 On reset all rsa_* outputs, in_ready, out_valid, busy and out_data SHALL be 0 at the next clock edge.
REQ-029 Reset mid-frame SHALL discard partial state; the core shares the same reset.
REQ-030 The first byte after reset release SHALL be treated as M byte 31.

Structure
REQ-031 The shared package SHALL hold the FSM state encoding (LOAD, START, WAIT, READ_REQ, READ_CAP, OUT, RELEASE, 3 bits) and the constants REG_M=2'b01, REG_E=2'b10, REG_N=2'b11, OPERAND_BYTES=32 and FRAME_BYTES=96.
REQ-032 The block SHALL have no sub-module; the counter and FSM are a single module, with the RSA core instantiated alongside at the top level.

Verification
REQ-033 The bench SHALL cover: M=2, E=3, N=11 (zero-padded to 256 bits), contiguous in_valid -> 32 out bytes, 31 bytes 0x00 then 0x08.
REQ-034 The bench SHALL cover: same frame with in_valid toggling every other cycle -> identical writes, no extra rsa_we pulses, exactly 96 writes.
REQ-035 The bench SHALL cover: out_ready held 0 for 10 cycles on byte 5 -> out_data stable, rsa_oe stays 1, no byte lost or duplicated.
REQ-036 The bench SHALL cover: reset asserted after 40 input bytes -> all outputs 0 next cycle; a fresh full frame then yields the correct result.
REQ-037 The bench SHALL cover: check the rsa_addr/rsa_reg_sel sequence -> byte 0 maps to (01,31), byte 32 to (10,31) and byte 95 to (11,0).
REQ-038 The bench SHALL cover: rsa_start is a single-cycle pulse, and busy=1 from START through RELEASE, 0 otherwise.
